// File: rtl/fht_unload_pkg.sv
// fht_unload shared definitions: size defaults, derived widths, FSM states.
package fht_unload_pkg;

  localparam int D_BIT_DEF = 17;
  localparam int A_BIT_DEF = 8;

  // Number of result points held across the four banks.
  function automatic int n_points(input int a_bit);
    return 4 << a_bit;
  endfunction

  // Point index width: bank address plus the 2-bit bank number.
  function automatic int idx_width(input int a_bit);
    return a_bit + 2;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

endpackage

// File: rtl/fht_unload_if.sv
// Result stream of the FHT unloader: one point per beat, valid/ready handshake.
interface fht_unload_if import fht_unload_pkg::*; #(
  parameter int D_BIT = D_BIT_DEF,
  parameter int A_BIT = A_BIT_DEF
);
  logic [D_BIT-1:0]            data;
  logic [idx_width(A_BIT)-1:0] index;
  logic                        valid;
  logic                        ready;
  logic                        last;

  modport master (output data, index, valid, last, input ready);
  modport slave  (input data, index, valid, last, output ready);
endinterface

// File: rtl/fht_unload_line.sv
// Ping-pong pair of 4-word line registers feeding the result stream.
// FHT_UNLOAD_ABS_EN: store saturated |x| at capture instead of the raw point.
module fht_unload_line import fht_unload_pkg::*; #(
  parameter int D_BIT = D_BIT_DEF,
  parameter int A_BIT = A_BIT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        cap,
  input  logic [3:0][D_BIT-1:0]       cap_data,
  input  logic                        ready,
  output logic [D_BIT-1:0]            data,
  output logic [idx_width(A_BIT)-1:0] index,
  output logic                        valid,
  output logic                        last,
  output logic [1:0]                  occ,
  output logic                        freeing
);
  logic [1:0][3:0][D_BIT-1:0] line_q, line_d;
  logic [1:0][A_BIT-1:0]      laddr_q, laddr_d;
  logic [1:0]                 lvld_q, lvld_d;
  logic                       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]                 bsel_q, bsel_d;
  logic [A_BIT-1:0]           wcnt_q, wcnt_d;
  logic [3:0][D_BIT-1:0]      cap_w;
  logic                       fire;

`ifdef FHT_UNLOAD_ABS_EN
  localparam logic [D_BIT-1:0] DMIN = {1'b1, {(D_BIT-1){1'b0}}};
  localparam logic [D_BIT-1:0] DMAX = {1'b0, {(D_BIT-1){1'b1}}};
  // Magnitude per bank; the most negative value saturates to the max positive.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cap_w[k] = cap_data[k];
      if (cap_data[k][D_BIT-1])
        cap_w[k] = (cap_data[k] == DMIN) ? DMAX : -cap_data[k];
    end
  end
`else
  assign cap_w = cap_data;
`endif

  assign valid   = lvld_q[rd_ptr_q];
  assign data    = line_q[rd_ptr_q][bsel_q];
  assign index   = {laddr_q[rd_ptr_q], bsel_q};
  assign last    = valid & (&index);  // index N-1 is all ones
  assign fire    = valid & ready;
  assign freeing = fire & (bsel_q == 2'd3);
  assign occ     = {1'b0, lvld_q[0]} + {1'b0, lvld_q[1]};

  // Beat select / line retire, and capture into the free line.
  always_comb begin
    line_d   = line_q;
    laddr_d  = laddr_q;
    lvld_d   = lvld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    bsel_d   = bsel_q;
    wcnt_d   = wcnt_q;
    if (clr) begin
      lvld_d   = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      bsel_d   = '0;
      wcnt_d   = '0;
    end else begin
      if (freeing) begin
        lvld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = ~rd_ptr_q;
        bsel_d           = '0;
      end else if (fire) begin
        bsel_d = bsel_q + 2'd1;
      end
      // Lines are captured in address order, so a counter tags them.
      if (cap) begin
        line_d[wr_ptr_q]  = cap_w;
        laddr_d[wr_ptr_q] = wcnt_q;
        lvld_d[wr_ptr_q]  = 1'b1;
        wr_ptr_d          = ~wr_ptr_q;
        wcnt_d            = wcnt_q + A_BIT'(1);
      end
    end
  end

  // Line state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q   <= '0;
      laddr_q  <= '0;
      lvld_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      bsel_q   <= '0;
      wcnt_q   <= '0;
    end else begin
      line_q   <= line_d;
      laddr_q  <= laddr_d;
      lvld_q   <= lvld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      bsel_q   <= bsel_d;
      wcnt_q   <= wcnt_d;
    end
  end
endmodule

// File: rtl/fht_unload.sv
// FHT result unloader: on the rising edge of iRDY read all four banks line by
// line and serialise the points in index order. Optional FHT_UNLOAD_ABS_EN
// turns the stream into saturated magnitudes.
module fht_unload import fht_unload_pkg::*; #(
  parameter int D_BIT = D_BIT_DEF,
  parameter int A_BIT = A_BIT_DEF
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iRDY,
  output logic [A_BIT-1:0] oADDR_RD,
  input  logic [D_BIT-1:0] iDATA_0,
  input  logic [D_BIT-1:0] iDATA_1,
  input  logic [D_BIT-1:0] iDATA_2,
  input  logic [D_BIT-1:0] iDATA_3,
  output logic             oBUSY,
  output logic             oABORT,
  fht_unload_if.master     st
);
  localparam logic [A_BIT:0] LINES = {1'b1, {A_BIT{1'b0}}};

  state_e           state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [A_BIT-1:0] addr_q, addr_d;
  logic [A_BIT:0]   nxt_q, nxt_d;       // next line address to issue
  logic [1:0]       vld_pipe_q, vld_pipe_d; // read in flight: issued, RAM sampled
  logic             busy_q, busy_d, abort_q, abort_d;
  logic             start, abort, done, cap, clr, can_issue;
  logic             l_valid, l_last, l_free;
  logic [1:0]       occ;
  logic [2:0]       used;

  fht_unload_line #(.D_BIT(D_BIT), .A_BIT(A_BIT)) u_line (
    .clk      (iCLK),
    .rst_n    (iRESET),
    .clr      (clr),
    .cap      (cap),
    .cap_data ({iDATA_3, iDATA_2, iDATA_1, iDATA_0}),
    .ready    (st.ready),
    .data     (st.data),
    .index    (st.index),
    .valid    (l_valid),
    .last     (l_last),
    .occ      (occ),
    .freeing  (l_free)
  );

  assign st.valid = l_valid;
  assign st.last  = l_last;
  assign oADDR_RD = addr_q;
  assign oBUSY    = busy_q;
  assign oABORT   = abort_q;

  // Sequencing: edge detect, read issue gated on line credits, abort.
  always_comb begin
    start     = iRDY & ~rdy_q;
    abort     = (state_q != ST_IDLE) & ~iRDY;
    done      = (state_q == ST_EMIT) & l_valid & st.ready & l_last;
    // Lines held plus reads in flight; a line retiring this edge frees a slot.
    used      = {1'b0, occ} + {2'b0, vld_pipe_q[0]} + {2'b0, vld_pipe_q[1]};
    can_issue = (state_q != ST_IDLE) & (nxt_q != LINES) &
                (used < (3'd2 + {2'b0, l_free}));
    cap       = vld_pipe_q[1] & ~abort;
    clr       = abort | done;

    state_d    = state_q;
    rdy_d      = iRDY;
    addr_d     = addr_q;
    nxt_d      = nxt_q;
    vld_pipe_d = {vld_pipe_q[0], 1'b0};
    busy_d     = busy_q;
    abort_d    = 1'b0;

    if (can_issue) begin
      addr_d        = nxt_q[A_BIT-1:0];
      nxt_d         = nxt_q + {{A_BIT{1'b0}}, 1'b1};
      vld_pipe_d[0] = 1'b1;
    end

    case (state_q)
      ST_IDLE: if (start) begin
        state_d       = ST_FETCH;
        addr_d        = '0;
        nxt_d         = {{A_BIT{1'b0}}, 1'b1};
        vld_pipe_d[0] = 1'b1;
        busy_d        = 1'b1;
      end
      ST_FETCH: if (vld_pipe_q[1]) state_d = ST_EMIT;
      ST_EMIT: if (done) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        addr_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // RAM(A) is being overwritten: drop everything in flight.
    if (abort) begin
      state_d    = ST_IDLE;
      busy_d     = 1'b0;
      addr_d     = '0;
      vld_pipe_d = '0;
      abort_d    = 1'b1;
    end
  end

  // FSM and control registers.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b1;
      addr_q     <= '0;
      nxt_q      <= '0;
      vld_pipe_q <= '0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      addr_q     <= addr_d;
      nxt_q      <= nxt_d;
      vld_pipe_q <= vld_pipe_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
    end
  end
endmodule

// File: tb/tb_fht_unload.sv
// Bench for fht_unload with A_BIT = 2 (16 points) and a registered RAM model.
module tb_fht_unload;
  localparam int DB = 17;
  localparam int AB = 2;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rdy = 1'b1;
  logic [AB-1:0] addr;
  logic [DB-1:0] d0, d1, d2, d3;
  logic          busy, abrt;

  fht_unload_if #(.D_BIT(DB), .A_BIT(AB)) st();

  fht_unload #(.D_BIT(DB), .A_BIT(AB)) dut (
    .iCLK(clk), .iRESET(rst_n), .iRDY(rdy), .oADDR_RD(addr),
    .iDATA_0(d0), .iDATA_1(d1), .iDATA_2(d2), .iDATA_3(d3),
    .oBUSY(busy), .oABORT(abrt), .st(st)
  );

  always #5 clk = ~clk;

  // bank x address result memory, 1-cycle registered read
  logic [DB-1:0] mem [4][4];
  always @(posedge clk) begin
    d0 <= mem[0][addr];
    d1 <= mem[1][addr];
    d2 <= mem[2][addr];
    d3 <= mem[3][addr];
  end

  int total = 0;
  int bad = 0;

  logic [DB-1:0] q_data[$];
  int            q_idx[$];
  logic          q_last[$];
  int            q_edge[$];
  int            first_vld, stall_viol, busy_drop, timeout;
  logic          busy_after, busy_c0, hold_vld;
  logic [AB-1:0] addr_c0, hold_addr;
  logic [3:0]    hold_idx;

  // Expected stream word for a stored point.
  function automatic logic [DB-1:0] ref_out(input logic [DB-1:0] x);
    int v;
    v = int'($signed(x));
`ifdef FHT_UNLOAD_ABS_EN
    if (v < 0) v = -v;
    if (v > 65535) v = 65535;
`endif
    return v[DB-1:0];
  endfunction

  task automatic load_ramp();
    for (int a = 0; a < 4; a++)
      for (int k = 0; k < 4; k++) mem[k][a] = DB'(100 * a + k);
  endtask

  task automatic load_rand();
    for (int a = 0; a < 4; a++)
      for (int k = 0; k < 4; k++) mem[k][a] = DB'($urandom);
  endtask

  // iRDY 1 -> 0 -> 1; the next rising clock edge is detect edge 0.
  task automatic kick();
    @(negedge clk) rdy = 1'b0;
    @(negedge clk) rdy = 1'b1;
  endtask

  // Drive iREADY and record accepted beats; c counts negedges after edge c.
  task automatic run_stream(input int pct, input int hold, input int budget);
    logic pv, pl;
    logic [DB-1:0] pd;
    logic [3:0] pi;
    q_data.delete(); q_idx.delete(); q_last.delete(); q_edge.delete();
    first_vld = -1; stall_viol = 0; busy_drop = 0; timeout = 0; busy_after = 1'b1;
    hold_addr = '0; hold_vld = 1'b0; hold_idx = '1;
    pv = 1'b0; pl = 1'b0; pd = '0; pi = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 0) begin addr_c0 = addr; busy_c0 = busy; end
      if (pv && (st.valid !== 1'b1 || st.data !== pd || st.index !== pi || st.last !== pl))
        stall_viol++;
      if (st.valid === 1'b1 && first_vld < 0) first_vld = c;
      if (c == hold - 1) begin hold_addr = addr; hold_vld = st.valid; hold_idx = st.index; end
      if (q_idx.size() == N) begin
        busy_after = busy;
        st.ready = 1'b0;
        return;
      end
      if (busy !== 1'b1) busy_drop++;
      st.ready = (c >= hold) && (int'($urandom_range(0, 99)) < pct);
      if (st.valid === 1'b1 && st.ready) begin
        q_data.push_back(st.data);
        q_idx.push_back(int'(st.index));
        q_last.push_back(st.last);
        q_edge.push_back(c + 1);
      end
      pv = (st.valid === 1'b1) && !st.ready;
      pd = st.data; pi = st.index; pl = st.last;
    end
    timeout = 1;
    st.ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (addr !== '0)     begin bad++; $display("FAIL rst_addr got=%0h exp=0", addr); end
    total++; if (st.data !== '0)  begin bad++; $display("FAIL rst_data got=%0h exp=0", st.data); end
    total++; if (st.index !== '0) begin bad++; $display("FAIL rst_index got=%0h exp=0", st.index); end
    total++; if (st.valid !== 0)  begin bad++; $display("FAIL rst_valid got=%0b exp=0", st.valid); end
    total++; if (st.last !== 0)   begin bad++; $display("FAIL rst_last got=%0b exp=0", st.last); end
    total++; if (busy !== 0)      begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (abrt !== 0)      begin bad++; $display("FAIL rst_abort got=%0b exp=0", abrt); end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      total++;
      if (busy !== 0 || st.valid !== 0) begin
        bad++; $display("FAIL rst_release_idle busy=%0b valid=%0b exp=0/0", busy, st.valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    load_ramp();
    st.ready = 1'b1;
    kick();
    repeat (6) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%0b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    total++;
    if (addr !== '0 || st.data !== '0 || st.index !== '0 || st.valid !== 0 ||
        st.last !== 0 || busy !== 0 || abrt !== 0) begin
      bad++;
      $display("FAIL mid_reset_outputs addr=%0h data=%0h idx=%0h v=%0b l=%0b b=%0b a=%0b exp=all 0",
               addr, st.data, st.index, st.valid, st.last, busy, abrt);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      total++;
      if (busy !== 0 || st.valid !== 0) begin
        bad++; $display("FAIL mid_no_retrigger busy=%0b valid=%0b exp=0/0", busy, st.valid);
      end
    end
    st.ready = 1'b0;
  endtask

  task automatic test_full();
    load_ramp();
    st.ready = 1'b0;
    kick();
    run_stream(100, 0, 200);
    total++; if (timeout != 0 || q_idx.size() != N) begin bad++; $display("FAIL full_count got=%0d exp=%0d", q_idx.size(), N); end
    total++; if (addr_c0 !== '0 || busy_c0 !== 1'b1) begin bad++; $display("FAIL full_edge0 addr=%0h busy=%0b exp=0/1", addr_c0, busy_c0); end
    total++; if (first_vld != 2) begin bad++; $display("FAIL full_latency got=%0d exp=2", first_vld); end
    for (int i = 0; i < q_idx.size(); i++) begin
      total++;
      if (q_idx[i] != i || q_data[i] !== ref_out(mem[i % 4][i / 4]) || q_last[i] !== (i == N - 1) || q_edge[i] != 3 + i) begin
        bad++;
        $display("FAIL full_beat[%0d] idx=%0d data=%0d last=%0b edge=%0d exp idx=%0d data=%0d last=%0b edge=%0d",
                 i, q_idx[i], q_data[i], q_last[i], q_edge[i], i, ref_out(mem[i % 4][i / 4]), i == N - 1, 3 + i);
      end
    end
    total++; if (busy_after !== 1'b0 || busy_drop != 0) begin bad++; $display("FAIL full_busy_fall after=%0b early_drops=%0d exp=0/0", busy_after, busy_drop); end
  endtask

  task automatic test_backpressure();
    load_ramp();
    kick();
    run_stream(50, 0, 400);
    total++; if (timeout != 0 || q_idx.size() != N) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", q_idx.size(), N); end
    for (int i = 0; i < q_idx.size(); i++) begin
      total++;
      if (q_idx[i] != i || q_data[i] !== ref_out(mem[i % 4][i / 4]) || q_last[i] !== (i == N - 1)) begin
        bad++;
        $display("FAIL bp_beat[%0d] idx=%0d data=%0d last=%0b exp idx=%0d data=%0d", i, q_idx[i], q_data[i], q_last[i], i, ref_out(mem[i % 4][i / 4]));
      end
    end
    total++; if (stall_viol != 0) begin bad++; $display("FAIL bp_stable got=%0d changes exp=0", stall_viol); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL bp_busy_fall got=%0b exp=0", busy_after); end
  endtask

  task automatic test_stall_start();
    load_ramp();
    kick();
    run_stream(100, 20, 200);
    total++; if (hold_addr !== 2'd1) begin bad++; $display("FAIL stall_addr got=%0d exp=1", hold_addr); end
    total++; if (hold_vld !== 1'b1 || hold_idx !== 4'd0) begin bad++; $display("FAIL stall_hold valid=%0b idx=%0d exp=1/0", hold_vld, hold_idx); end
    total++; if (stall_viol != 0) begin bad++; $display("FAIL stall_stable got=%0d exp=0", stall_viol); end
    total++; if (timeout != 0 || q_idx.size() != N) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", q_idx.size(), N); end
    for (int i = 0; i < q_idx.size(); i++) begin
      total++;
      if (q_idx[i] != i || q_data[i] !== ref_out(mem[i % 4][i / 4]) || q_edge[i] != 21 + i) begin
        bad++;
        $display("FAIL stall_beat[%0d] idx=%0d data=%0d edge=%0d exp idx=%0d data=%0d edge=%0d", i, q_idx[i], q_data[i], q_edge[i], i, ref_out(mem[i % 4][i / 4]), 21 + i);
      end
    end
  endtask

  task automatic test_abort();
    int acc, c;
    load_ramp();
    st.ready = 1'b1;
    kick();
    acc = 0; c = 0;
    while (acc < 6 && c < 60) begin
      @(negedge clk);
      if (st.valid === 1'b1 && st.ready) acc++;
      c++;
    end
    total++; if (acc != 6) begin bad++; $display("FAIL abort_reach got=%0d beats exp=6", acc); end
    @(negedge clk);
    total++; if (st.valid !== 1'b1 || st.index !== 4'd6) begin bad++; $display("FAIL abort_pre valid=%0b idx=%0d exp=1/6", st.valid, st.index); end
    rdy = 1'b0;
    st.ready = 1'b0;
    @(negedge clk);
    total++; if (abrt !== 1'b1) begin bad++; $display("FAIL abort_pulse got=%0b exp=1", abrt); end
    total++;
    if (st.valid !== 0 || busy !== 0 || addr !== '0 || st.last !== 0) begin
      bad++; $display("FAIL abort_clear valid=%0b busy=%0b addr=%0d last=%0b exp=0/0/0/0", st.valid, busy, addr, st.last);
    end
    @(negedge clk);
    total++; if (abrt !== 1'b0) begin bad++; $display("FAIL abort_single got=%0b exp=0", abrt); end
    kick();
    run_stream(100, 0, 200);
    total++; if (timeout != 0 || q_idx.size() != N || first_vld != 2) begin bad++; $display("FAIL abort_restart count=%0d lat=%0d exp=%0d/2", q_idx.size(), first_vld, N); end
    for (int i = 0; i < q_idx.size(); i++) begin
      total++;
      if (q_idx[i] != i || q_data[i] !== ref_out(mem[i % 4][i / 4])) begin
        bad++; $display("FAIL abort_beat[%0d] idx=%0d data=%0d exp idx=%0d data=%0d", i, q_idx[i], q_data[i], i, ref_out(mem[i % 4][i / 4]));
      end
    end
  endtask

  task automatic test_abs_data();
    logic [DB-1:0] exp4 [4];
`ifdef FHT_UNLOAD_ABS_EN
    exp4[0] = 17'd5; exp4[1] = 17'd7; exp4[2] = 17'd65535; exp4[3] = 17'd0;
`else
    exp4[0] = 17'h1FFFB; exp4[1] = 17'd7; exp4[2] = 17'h10000; exp4[3] = 17'd0;
`endif
    load_rand();
    mem[0][0] = -17'sd5; mem[1][0] = 17'd7; mem[2][0] = 17'h10000; mem[3][0] = 17'd0;
    kick();
    run_stream(100, 0, 200);
    total++; if (timeout != 0 || q_idx.size() != N) begin bad++; $display("FAIL abs_count got=%0d exp=%0d", q_idx.size(), N); end
    for (int i = 0; i < q_idx.size(); i++) begin
      total++;
      if (i < 4 && q_data[i] !== exp4[i]) begin
        bad++; $display("FAIL abs_fixed[%0d] got=%0h exp=%0h", i, q_data[i], exp4[i]);
      end else if (i >= 4 && (q_data[i] !== ref_out(mem[i % 4][i / 4]) || q_idx[i] != i)) begin
        bad++; $display("FAIL abs_beat[%0d] got=%0h idx=%0d exp=%0h idx=%0d", i, q_data[i], q_idx[i], ref_out(mem[i % 4][i / 4]), i);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      load_rand();
      kick();
      run_stream(int'($urandom_range(20, 90)), 0, 600);
      total++; if (timeout != 0 || q_idx.size() != N || stall_viol != 0) begin bad++; $display("FAIL rnd%0d_stream count=%0d stable_err=%0d exp=%0d/0", it, q_idx.size(), stall_viol, N); end
      for (int i = 0; i < q_idx.size(); i++) begin
        total++;
        if (q_idx[i] != i || q_data[i] !== ref_out(mem[i % 4][i / 4]) || q_last[i] !== (i == N - 1)) begin
          bad++; $display("FAIL rnd%0d_beat[%0d] idx=%0d data=%0h exp idx=%0d data=%0h", it, i, q_idx[i], q_data[i], i, ref_out(mem[i % 4][i / 4]));
        end
      end
    end
  endtask

  initial begin
    st.ready = 1'b0;
    load_ramp();
    repeat (3) @(negedge clk);
    test_reset();
    test_full();
    test_backpressure();
    test_stall_start();
    test_abort();
    test_abs_data();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
